// File: rtl/imm_gen_queue.sv
// imm_gen_queue: buffered RISC-V immediate generator.
// Instructions enter over a valid/ready handshake. Each one is decoded into
// an immediate plus a format code and stored in an in-order FIFO. The FIFO
// head is presented to the operand side over its own valid/ready handshake.
// Optional feature macro: IMMGEN_CSR_IMM_EN. When it is defined, the CSR
// immediate forms (csrrwi/csrrsi/csrrci) decode as format Z with a
// zero-extended uimm.
// Every output comes from a register, so there is no combinational path
// from Instr, InValid, OutReady or Flush to any output.
module imm_gen_queue #(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 4,
  localparam int CNTW  = $clog2(QDEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     Instr,
  input  logic            InValid,
  output logic            InReady,
  input  logic            Flush,
  output logic [XLEN-1:0] ImmExt,
  output logic [2:0]      ImmType,
  output logic            Illegal,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [CNTW-1:0] Count
);

  localparam int PW = $clog2(QDEPTH);

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
  localparam logic [2:0] T_Z    = 3'd6;

  localparam logic [CNTW-1:0] C_FULL = CNTW'(QDEPTH);

  // Sign-extend a 32-bit immediate to the datapath width.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // Decoder results for the word currently on Instr.
  logic [XLEN-1:0] w_dec_imm;
  logic [2:0]      w_dec_type;
  logic            w_dec_ill;

  // FIFO state.
  logic [XLEN-1:0] r_mem_imm  [QDEPTH];
  logic [2:0]      r_mem_type [QDEPTH];
  logic            r_mem_ill  [QDEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;

  // Registered head/handshake outputs.
  logic [XLEN-1:0] r_head_imm;
  logic [2:0]      r_head_type;
  logic            r_head_ill;
  logic            r_out_valid;
  logic            r_in_ready;

  // Next-state values.
  logic            w_push;
  logic            w_pop;
  logic [PW-1:0]   w_wr_ptr_nxt;
  logic [PW-1:0]   w_rd_ptr_nxt;
  logic [CNTW-1:0] w_count_nxt;
  logic [CNTW-1:0] w_after_pop;
  logic [XLEN-1:0] w_head_imm_nxt;
  logic [2:0]      w_head_type_nxt;
  logic            w_head_ill_nxt;

  // Decode the immediate and its format from the offered instruction word.
  always_comb begin
    w_dec_imm  = {XLEN{1'b0}};
    w_dec_type = T_NONE;
    w_dec_ill  = 1'b0;
    if (Instr[1:0] != 2'b11) begin
      w_dec_ill = 1'b1;
    end else begin
      case (Instr[6:0])
        7'b0010011, 7'b0000011, 7'b1100111: begin
          w_dec_type = T_I;
          w_dec_imm  = sext32({{20{Instr[31]}}, Instr[31:20]});
        end
        7'b0011011: begin
          // OP-IMM-32 exists only on RV64.
          if (XLEN == 64) begin
            w_dec_type = T_I;
            w_dec_imm  = sext32({{20{Instr[31]}}, Instr[31:20]});
          end else begin
            w_dec_type = T_NONE;
            w_dec_imm  = {XLEN{1'b0}};
          end
        end
        7'b0100011: begin
          w_dec_type = T_S;
          w_dec_imm  = sext32({{20{Instr[31]}}, Instr[31:25], Instr[11:7]});
        end
        7'b1100011: begin
          w_dec_type = T_B;
          w_dec_imm  = sext32({{19{Instr[31]}}, Instr[31], Instr[7],
                               Instr[30:25], Instr[11:8], 1'b0});
        end
        7'b0110111, 7'b0010111: begin
          w_dec_type = T_U;
          w_dec_imm  = sext32({Instr[31:12], 12'h000});
        end
        7'b1101111: begin
          w_dec_type = T_J;
          w_dec_imm  = sext32({{11{Instr[31]}}, Instr[31], Instr[19:12],
                               Instr[20], Instr[30:21], 1'b0});
        end
`ifdef IMMGEN_CSR_IMM_EN
        7'b1110011: begin
          // funct3 101/110/111 are the immediate CSR forms.
          if (Instr[14] && (Instr[13:12] != 2'b00)) begin
            w_dec_type = T_Z;
            w_dec_imm  = XLEN'(Instr[19:15]);
          end else begin
            w_dec_type = T_NONE;
            w_dec_imm  = {XLEN{1'b0}};
          end
        end
`endif
        default: begin
          w_dec_type = T_NONE;
          w_dec_imm  = {XLEN{1'b0}};
        end
      endcase
    end
  end

  // Handshakes, pointer and occupancy updates; Flush overrides push and pop.
  always_comb begin
    w_push       = InValid & r_in_ready & ~Flush;
    w_pop        = r_out_valid & OutReady & ~Flush;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    w_after_pop  = r_count - CNTW'(w_pop);
    if (Flush) begin
      w_wr_ptr_nxt = {PW{1'b0}};
      w_rd_ptr_nxt = {PW{1'b0}};
      w_count_nxt  = {CNTW{1'b0}};
    end else begin
      w_wr_ptr_nxt = r_wr_ptr + PW'(w_push);
      w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
      w_count_nxt  = w_after_pop + CNTW'(w_push);
    end
  end

  // Pick the entry that will sit at the head after this edge; keep the old
  // head values when the FIFO will be empty.
  always_comb begin
    w_head_imm_nxt  = r_head_imm;
    w_head_type_nxt = r_head_type;
    w_head_ill_nxt  = r_head_ill;
    if (Flush || (w_count_nxt == {CNTW{1'b0}})) begin
      w_head_imm_nxt  = r_head_imm;
      w_head_type_nxt = r_head_type;
      w_head_ill_nxt  = r_head_ill;
    end else if (w_after_pop == {CNTW{1'b0}}) begin
      // Nothing left in storage, so the word being pushed becomes the head.
      w_head_imm_nxt  = w_dec_imm;
      w_head_type_nxt = w_dec_type;
      w_head_ill_nxt  = w_dec_ill;
    end else begin
      w_head_imm_nxt  = r_mem_imm[w_rd_ptr_nxt];
      w_head_type_nxt = r_mem_type[w_rd_ptr_nxt];
      w_head_ill_nxt  = r_mem_ill[w_rd_ptr_nxt];
    end
  end

  // FIFO storage write; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_imm[r_wr_ptr]  <= w_dec_imm;
      r_mem_type[r_wr_ptr] <= w_dec_type;
      r_mem_ill[r_wr_ptr]  <= w_dec_ill;
    end
  end

  // Pointer, occupancy and registered output state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= {PW{1'b0}};
      r_rd_ptr    <= {PW{1'b0}};
      r_count     <= {CNTW{1'b0}};
      r_head_imm  <= {XLEN{1'b0}};
      r_head_type <= T_NONE;
      r_head_ill  <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_head_imm  <= w_head_imm_nxt;
      r_head_type <= w_head_type_nxt;
      r_head_ill  <= w_head_ill_nxt;
      r_out_valid <= (w_count_nxt != {CNTW{1'b0}});
      r_in_ready  <= (w_count_nxt < C_FULL);
    end
  end

  assign InReady  = r_in_ready;
  assign OutValid = r_out_valid;
  assign ImmExt   = r_head_imm;
  assign ImmType  = r_head_type;
  assign Illegal  = r_head_ill;
  assign Count    = r_count;

endmodule

// File: tb/tb_imm_gen_queue.sv
// Testbench for imm_gen_queue: directed scenarios plus randomized traffic
// against a queue-based reference model that decodes with plain arithmetic.
module tb_imm_gen_queue;

  localparam int XLEN   = 32;
  localparam int QDEPTH = 4;
  localparam int CNTW   = $clog2(QDEPTH) + 1;

  typedef struct {
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic            ill;
  } ent_t;

  logic            clk;
  logic            rst_n;
  logic [31:0]     Instr;
  logic            InValid;
  logic            InReady;
  logic            Flush;
  logic [XLEN-1:0] ImmExt;
  logic [2:0]      ImmType;
  logic            Illegal;
  logic            OutValid;
  logic            OutReady;
  logic [CNTW-1:0] Count;

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t mq[$];
  ent_t last_head;

  imm_gen_queue #(.XLEN(XLEN), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .Instr(Instr), .InValid(InValid),
    .InReady(InReady), .Flush(Flush), .ImmExt(ImmExt), .ImmType(ImmType),
    .Illegal(Illegal), .OutValid(OutValid), .OutReady(OutReady), .Count(Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode computed from the field definitions with arithmetic.
  function automatic ent_t ref_decode(input logic [31:0] w);
    ent_t   e;
    longint x;
    longint v;
    int     bits;
    int     op;
    int     f3;
    x = longint'(w);
    e.imm = '0; e.typ = 3'd0; e.ill = 1'b0;
    op = int'(x % 128);
    f3 = int'((x / 4096) % 8);
    v = 0; bits = 0;
    if ((x % 4) != 3) begin
      e.ill = 1'b1;
      return e;
    end
    if (op == 'h13 || op == 'h03 || op == 'h67 || (op == 'h1B && XLEN == 64)) begin
      e.typ = 3'd1; v = x / (1 << 20); bits = 12;
    end else if (op == 'h23) begin
      e.typ = 3'd2; v = ((x >> 25) % 128) * 32 + ((x >> 7) % 32); bits = 12;
    end else if (op == 'h63) begin
      e.typ = 3'd3;
      v = ((x >> 31) % 2) * 4096 + ((x >> 7) % 2) * 2048
        + ((x >> 25) % 64) * 32 + ((x >> 8) % 16) * 2;
      bits = 13;
    end else if (op == 'h37 || op == 'h17) begin
      e.typ = 3'd4; v = (x / 4096) * 4096; bits = 32;
    end else if (op == 'h6F) begin
      e.typ = 3'd5;
      v = ((x >> 31) % 2) * (1 << 20) + ((x >> 12) % 256) * 4096
        + ((x >> 20) % 2) * 2048 + ((x >> 21) % 1024) * 2;
      bits = 21;
`ifdef IMMGEN_CSR_IMM_EN
    end else if (op == 'h73 && f3 >= 5) begin
      e.typ = 3'd6; v = (x >> 15) % 32; bits = 0;
`endif
    end else begin
      e.typ = 3'd0; v = 0; bits = 0;
    end
    if (bits > 0 && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    e.imm = XLEN'(v);
    return e;
  endfunction

  // One clock: drive inputs, advance DUT and model, settle 1 time unit past the edge.
  task automatic tick(input logic v, input logic [31:0] ins, input logic rdy,
                      input logic fl, output logic acc);
    logic m_push;
    logic m_pop;
    InValid = v; Instr = ins; OutReady = rdy; Flush = fl;
    m_push = v && (mq.size() < QDEPTH) && !fl;
    m_pop  = (mq.size() > 0) && rdy && !fl;
    acc = m_push;
    @(posedge clk); #1;
    if (fl) mq.delete();
    else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(ref_decode(ins));
    end
    if (mq.size() > 0) last_head = mq[0];
    InValid = 1'b0; Flush = 1'b0;
  endtask

  task automatic test_reset;
    if (Count !== 3'd0) begin n_errors++; $display("FAIL reset_count: got %0d exp 0", Count); end
    n_checks++;
    if (OutValid !== 1'b0) begin n_errors++; $display("FAIL reset_outvalid: got %b exp 0", OutValid); end
    n_checks++;
    if (InReady !== 1'b1) begin n_errors++; $display("FAIL reset_inready: got %b exp 1", InReady); end
    n_checks++;
    if (ImmExt !== 32'h0 || ImmType !== 3'd0 || Illegal !== 1'b0) begin
      n_errors++; $display("FAIL reset_head: got %h/%0d/%b exp 0/0/0", ImmExt, ImmType, Illegal);
    end
    n_checks++;
  endtask

  task automatic test_addi;
    logic a;
    tick(1'b1, 32'hFFF00093, 1'b1, 1'b0, a);
    if (OutValid !== 1'b1 || ImmExt !== 32'hFFFFFFFF || ImmType !== 3'd1) begin
      n_errors++; $display("FAIL addi_head: got v=%b %h/%0d exp v=1 ffffffff/1", OutValid, ImmExt, ImmType);
    end
    n_checks++;
    tick(1'b0, 32'h0, 1'b1, 1'b0, a);
    if (OutValid !== 1'b0 || Count !== 3'd0) begin
      n_errors++; $display("FAIL addi_drain: got v=%b cnt=%0d exp v=0 cnt=0", OutValid, Count);
    end
    n_checks++;
    if (ImmExt !== 32'hFFFFFFFF || ImmType !== 3'd1) begin
      n_errors++; $display("FAIL addi_hold: got %h/%0d exp ffffffff/1", ImmExt, ImmType);
    end
    n_checks++;
  endtask

  task automatic test_formats;
    logic [31:0] words [3] = '{32'hFE112E23, 32'hFF9FF06F, 32'h800002B7};
    logic [31:0] eimm  [3] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h80000000};
    logic [2:0]  etyp  [3] = '{3'd2, 3'd5, 3'd4};
    logic a;
    for (int i = 0; i < 3; i++) tick(1'b1, words[i], 1'b0, 1'b0, a);
    if (Count !== 3'd3) begin n_errors++; $display("FAIL formats_count: got %0d exp 3", Count); end
    n_checks++;
    for (int i = 0; i < 3; i++) begin
      if (OutValid !== 1'b1 || ImmExt !== eimm[i] || ImmType !== etyp[i]) begin
        n_errors++;
        $display("FAIL formats_drain%0d: got v=%b %h/%0d exp v=1 %h/%0d", i, OutValid, ImmExt, ImmType, eimm[i], etyp[i]);
      end
      n_checks++;
      tick(1'b0, 32'h0, 1'b1, 1'b0, a);
    end
    if (OutValid !== 1'b0) begin n_errors++; $display("FAIL formats_empty: got %b exp 0", OutValid); end
    n_checks++;
  endtask

  task automatic test_full_wrap;
    logic        a;
    int          idx = 0;
    int          got = 0;
    logic [31:0] w;
    for (int i = 0; i < 6; i++) begin
      w = (32'(idx + 1) << 20) | 32'h93;
      tick(1'b1, w, 1'b0, 1'b0, a);
      if (a) idx++;
      if (InReady !== (idx < QDEPTH)) begin
        n_errors++; $display("FAIL full_inready%0d: got %b exp %b", i, InReady, idx < QDEPTH);
      end
      n_checks++;
    end
    if (Count !== 3'd4 || idx != 4) begin n_errors++; $display("FAIL full_count: got %0d exp 4", Count); end
    n_checks++;
    for (int cyc = 0; cyc < 20 && got < 6; cyc++) begin
      if (OutValid === 1'b1) begin
        if (ImmExt !== 32'(got + 1)) begin
          n_errors++; $display("FAIL wrap_order%0d: got %h exp %h", got, ImmExt, 32'(got + 1));
        end
        n_checks++;
        got++;
      end
      w = (32'(idx + 1) << 20) | 32'h93;
      tick(idx < 6, w, 1'b1, 1'b0, a);
      if (a) idx++;
      if (cyc == 0) begin
        if (Count !== 3'd3 || idx != 4) begin
          n_errors++; $display("FAIL full_poponly: got cnt=%0d exp 3", Count);
        end
        n_checks++;
        if (InReady !== 1'b1) begin n_errors++; $display("FAIL full_inready_rise: got %b exp 1", InReady); end
        n_checks++;
      end
    end
    if (got != 6) begin n_errors++; $display("FAIL wrap_timeout: got %0d words exp 6", got); end
    n_checks++;
  endtask

  task automatic test_flush;
    logic a;
    for (int i = 0; i < 3; i++) tick(1'b1, 32'h00500093 + (32'(i) << 20), 1'b0, 1'b0, a);
    if (Count !== 3'd3) begin n_errors++; $display("FAIL flush_pre: got %0d exp 3", Count); end
    n_checks++;
    tick(1'b1, 32'h06300093, 1'b1, 1'b1, a);
    if (Count !== 3'd0 || OutValid !== 1'b0) begin
      n_errors++; $display("FAIL flush_clear: got cnt=%0d v=%b exp 0/0", Count, OutValid);
    end
    n_checks++;
    tick(1'b1, 32'h02A00093, 1'b0, 1'b0, a);
    if (Count !== 3'd1 || ImmExt !== 32'd42) begin
      n_errors++; $display("FAIL flush_restart: got cnt=%0d %h exp 1 0000002a", Count, ImmExt);
    end
    n_checks++;
    tick(1'b0, 32'h0, 1'b1, 1'b0, a);
  endtask

  task automatic test_none_illegal;
    logic a;
    tick(1'b1, 32'h00000033, 1'b0, 1'b0, a);
    tick(1'b1, 32'h00000000, 1'b0, 1'b0, a);
    if (ImmType !== 3'd0 || ImmExt !== 32'h0 || Illegal !== 1'b0) begin
      n_errors++; $display("FAIL rtype: got %h/%0d/%b exp 0/0/0", ImmExt, ImmType, Illegal);
    end
    n_checks++;
    tick(1'b0, 32'h0, 1'b1, 1'b0, a);
    if (ImmType !== 3'd0 || ImmExt !== 32'h0 || Illegal !== 1'b1) begin
      n_errors++; $display("FAIL illegal: got %h/%0d/%b exp 0/0/1", ImmExt, ImmType, Illegal);
    end
    n_checks++;
    tick(1'b0, 32'h0, 1'b1, 1'b0, a);
  endtask

  task automatic test_csr;
    logic        a;
    logic [31:0] eimm;
    logic [2:0]  etyp;
`ifdef IMMGEN_CSR_IMM_EN
    eimm = 32'd5; etyp = 3'd6;
`else
    eimm = 32'd0; etyp = 3'd0;
`endif
    tick(1'b1, 32'h3002D073, 1'b0, 1'b0, a);
    if (ImmExt !== eimm || ImmType !== etyp || Illegal !== 1'b0) begin
      n_errors++; $display("FAIL csr: got %h/%0d exp %h/%0d", ImmExt, ImmType, eimm, etyp);
    end
    n_checks++;
  endtask

  task automatic test_reset_mid;
    logic a;
    tick(1'b1, 32'h00100093, 1'b0, 1'b0, a);
    #2 rst_n = 1'b0;
    #1;
    if (Count !== 3'd0 || OutValid !== 1'b0 || InReady !== 1'b1 || ImmExt !== 32'h0) begin
      n_errors++; $display("FAIL reset_mid: got cnt=%0d v=%b r=%b %h exp 0/0/1/0", Count, OutValid, InReady, ImmExt);
    end
    n_checks++;
    mq.delete();
    last_head = '{imm: '0, typ: 3'd0, ill: 1'b0};
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [6:0]  ops [12] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63,
                               7'h37, 7'h17, 7'h6F, 7'h33, 7'h73, 7'h0F};
    logic        a;
    logic [31:0] w;
    logic [31:0] r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      w = (r & 32'hFFFFFF80) | 32'(ops[$urandom_range(0, 11)]);
      if ($urandom_range(0, 9) == 0) w = w & 32'hFFFFFFFC;
      tick($urandom_range(0, 2) != 0, w, $urandom_range(0, 2) == 0 ? 1'b0 : 1'b1,
           $urandom_range(0, 40) == 0, a);
      if (Count !== CNTW'(mq.size()) || OutValid !== (mq.size() != 0) || InReady !== (mq.size() < QDEPTH)) begin
        n_errors++;
        $display("FAIL rand_state%0d: got cnt=%0d v=%b r=%b exp cnt=%0d", i, Count, OutValid, InReady, mq.size());
      end
      n_checks++;
      if (ImmExt !== last_head.imm || ImmType !== last_head.typ || Illegal !== last_head.ill) begin
        n_errors++;
        $display("FAIL rand_head%0d: got %h/%0d/%b exp %h/%0d/%b", i, ImmExt, ImmType, Illegal,
                 last_head.imm, last_head.typ, last_head.ill);
      end
      n_checks++;
    end
  endtask

  initial begin
    rst_n = 1'b0; Instr = 32'h0; InValid = 1'b0; OutReady = 1'b0; Flush = 1'b0;
    last_head = '{imm: '0, typ: 3'd0, ill: 1'b0};
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_addi();
    test_formats();
    test_full_wrap();
    test_flush();
    test_none_illegal();
    test_csr();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
